// File: rtl/rps_match_scoreboard_if.sv
// Result/control bundle between the round judge side and the match scoreboard.
// The master drives round results and match starts; the slave reports match status.
interface rps_match_scoreboard_if;
    logic       res_valid;
    logic [1:0] res;
    logic       new_match;
    logic       in_ready;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] round_cnt;
    logic [3:0] invalid_cnt;
    logic       match_over;
    logic [1:0] winner;
    logic       winner_led;

    modport master (
        output res_valid, res, new_match,
        input  in_ready, p1_score, p2_score, round_cnt, invalid_cnt,
               match_over, winner, winner_led
    );

    modport slave (
        input  res_valid, res, new_match,
        output in_ready, p1_score, p2_score, round_cnt, invalid_cnt,
               match_over, winner, winner_led
    );
endinterface

// File: rtl/rps_match_scoreboard.sv
// First-to-N stone-paper-scissors match scoreboard: accumulates round results,
// decides the match by score or round limit and flashes the winner indicator.
module rps_match_scoreboard #(
    parameter int WINS_TO_TAKE = 3,
    parameter int MAX_ROUNDS   = 9,
    parameter int FLASH_DIV    = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    rps_match_scoreboard_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);
    localparam logic [3:0] WINS_L = 4'(WINS_TO_TAKE);
    localparam logic [3:0] MAX_L  = 4'(MAX_ROUNDS);

    state_t           state_r;
    logic [3:0]       p1_r, p2_r, rnd_r, inv_r;
    logic [1:0]       winner_r;
    logic             in_ready_r, match_over_r, led_r;
    logic [DIV_W-1:0] div_r;

    logic             accept_s;
    logic [3:0]       p1_nx_s, p2_nx_s, rnd_nx_s, inv_nx_s;
    logic             decide_s;
    logic [1:0]       winner_nx_s;

    // Post-update counter values and the end-of-match decision for an accepted result.
    always_comb begin
        p1_nx_s     = p1_r;
        p2_nx_s     = p2_r;
        rnd_nx_s    = rnd_r;
        inv_nx_s    = inv_r;
        decide_s    = 1'b0;
        winner_nx_s = 2'b00;
        accept_s    = (state_r == ST_PLAY) && bus.res_valid && !bus.new_match;
        if (accept_s) begin
            case (bus.res)
                2'b00: rnd_nx_s = rnd_r + 4'd1;
                2'b01: begin
                    p1_nx_s  = p1_r + 4'd1;
                    rnd_nx_s = rnd_r + 4'd1;
                end
                2'b10: begin
                    p2_nx_s  = p2_r + 4'd1;
                    rnd_nx_s = rnd_r + 4'd1;
                end
                2'b11: begin
                    if (inv_r != 4'd15) begin
                        inv_nx_s = inv_r + 4'd1;
                    end else begin
                        inv_nx_s = inv_r;
                    end
                end
                default: rnd_nx_s = rnd_r;
            endcase
        end else begin
            rnd_nx_s = rnd_r;
        end

        // A score win outranks the round limit reached by the same result.
        if (!accept_s) begin
            decide_s = 1'b0;
        end else if (p1_nx_s == WINS_L) begin
            decide_s    = 1'b1;
            winner_nx_s = 2'b01;
        end else if (p2_nx_s == WINS_L) begin
            decide_s    = 1'b1;
            winner_nx_s = 2'b10;
        end else if (rnd_nx_s == MAX_L) begin
            decide_s = 1'b1;
            if (p1_nx_s > p2_nx_s) begin
                winner_nx_s = 2'b01;
            end else if (p2_nx_s > p1_nx_s) begin
                winner_nx_s = 2'b10;
            end else begin
                winner_nx_s = 2'b00;
            end
        end else begin
            decide_s = 1'b0;
        end
    end

    // Match state machine with all counters and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            p1_r         <= 4'd0;
            p2_r         <= 4'd0;
            rnd_r        <= 4'd0;
            inv_r        <= 4'd0;
            winner_r     <= 2'b00;
            in_ready_r   <= 1'b0;
            match_over_r <= 1'b0;
            led_r        <= 1'b0;
            div_r        <= '0;
        end else if (bus.new_match) begin
            state_r      <= ST_PLAY;
            p1_r         <= 4'd0;
            p2_r         <= 4'd0;
            rnd_r        <= 4'd0;
            inv_r        <= 4'd0;
            winner_r     <= 2'b00;
            in_ready_r   <= 1'b1;
            match_over_r <= 1'b0;
            led_r        <= 1'b0;
            div_r        <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                end
                ST_PLAY: begin
                    p1_r  <= p1_nx_s;
                    p2_r  <= p2_nx_s;
                    rnd_r <= rnd_nx_s;
                    inv_r <= inv_nx_s;
                    if (decide_s) begin
                        state_r      <= ST_DONE;
                        winner_r     <= winner_nx_s;
                        in_ready_r   <= 1'b0;
                        match_over_r <= 1'b1;
                        led_r        <= (winner_nx_s != 2'b00);
                        div_r        <= '0;
                    end else begin
                        state_r    <= ST_PLAY;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A draw keeps the indicator dark; otherwise toggle every FLASH_DIV cycles.
                    if (div_r == DIV_LAST) begin
                        div_r <= '0;
                        led_r <= (winner_r != 2'b00) ? ~led_r : 1'b0;
                    end else begin
                        div_r <= div_r + 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    in_ready_r   <= 1'b0;
                    match_over_r <= 1'b0;
                    led_r        <= 1'b0;
                    div_r        <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.p1_score    = p1_r;
    assign bus.p2_score    = p2_r;
    assign bus.round_cnt   = rnd_r;
    assign bus.invalid_cnt = inv_r;
    assign bus.match_over  = match_over_r;
    assign bus.winner      = winner_r;
    assign bus.winner_led  = led_r;
endmodule

// File: tb/tb_rps_match_scoreboard.sv
// Scoreboard bench for rps_match_scoreboard: directed test-plan sequences plus
// random traffic, checked every cycle against a behavioural match model.
module tb_rps_match_scoreboard;
    localparam int W  = 3;
    localparam int MR = 7;
    localparam int FD = 4;

    logic clk;
    logic rst;
    rps_match_scoreboard_if bus ();

    rps_match_scoreboard #(
        .WINS_TO_TAKE(W),
        .MAX_ROUNDS  (MR),
        .FLASH_DIV   (FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: match phase 0 idle, 1 play, 2 done; k = edges spent in done.
    int m_phase, m_p1, m_p2, m_rnd, m_inv, m_win, m_k;
    logic [20:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic model_step(input logic r, input logic nm, input logic rv, input logic [1:0] rs);
        if (r) begin
            m_phase = 0; m_p1 = 0; m_p2 = 0; m_rnd = 0; m_inv = 0; m_win = 0; m_k = 0;
        end else if (nm) begin
            m_phase = 1; m_p1 = 0; m_p2 = 0; m_rnd = 0; m_inv = 0; m_win = 0; m_k = 0;
        end else if (m_phase == 1 && rv) begin
            if (rs == 2'd3) m_inv = (m_inv < 15) ? m_inv + 1 : 15;
            else begin
                m_rnd++;
                if (rs == 2'd1) m_p1++;
                if (rs == 2'd2) m_p2++;
            end
            if (m_p1 >= W)       begin m_phase = 2; m_win = 1; m_k = 0; end
            else if (m_p2 >= W)  begin m_phase = 2; m_win = 2; m_k = 0; end
            else if (m_rnd >= MR) begin
                m_phase = 2; m_k = 0;
                m_win = (m_p1 > m_p2) ? 1 : ((m_p2 > m_p1) ? 2 : 0);
            end
        end else if (m_phase == 2) begin
            m_k++;
        end
    endtask

    function automatic logic [20:0] model_snapshot();
        logic led;
        led = (m_phase == 2) && (m_win != 0) && (((m_k / FD) % 2) == 0);
        return {(m_phase == 1), 4'(m_p1), 4'(m_p2), 4'(m_rnd), 4'(m_inv),
                (m_phase == 2), 2'(m_win), led};
    endfunction

    // One stimulus cycle: drive inputs, advance the model on the edge, queue the expectation.
    task automatic drive(input logic r, input logic nm, input logic rv, input logic [1:0] rs);
        rst           = r;
        bus.new_match = nm;
        bus.res_valid = rv;
        bus.res       = rs;
        @(posedge clk);
        model_step(r, nm, rv, rs);
        exp_q.push_back(model_snapshot());
        #1;
        rst = 1'b0; bus.new_match = 1'b0; bus.res_valid = 1'b0; bus.res = 2'b00;
    endtask

    task automatic play(input logic [1:0] rs);
        drive(1'b0, 1'b0, 1'b1, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Monitor: compare the DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] exp_v, act_v;
            exp_v = exp_q.pop_front();
            act_v = {bus.in_ready, bus.p1_score, bus.p2_score, bus.round_cnt, bus.invalid_cnt,
                     bus.match_over, bus.winner, bus.winner_led};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got rdy=%b p1=%0d p2=%0d rnd=%0d inv=%0d over=%b win=%b led=%b want rdy=%b p1=%0d p2=%0d rnd=%0d inv=%0d over=%b win=%b led=%b",
                         $time, act_v[20], act_v[19:16], act_v[15:12], act_v[11:8], act_v[7:4],
                         act_v[3], act_v[2:1], act_v[0], exp_v[20], exp_v[19:16], exp_v[15:12],
                         exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2:1], exp_v[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; bus.new_match = 1'b0; bus.res_valid = 1'b0; bus.res = 2'b00;
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 2'b01);
        idle(2);

        drive(1'b0, 1'b1, 1'b0, 2'b00);
        play(2'b01); play(2'b10); play(2'b01); play(2'b00); play(2'b01);
        play(2'b10);
        idle(3);

        drive(1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 17; i++) play(2'b11);
        idle(2);

        drive(1'b0, 1'b1, 1'b0, 2'b00);
        play(2'b01); play(2'b10); play(2'b00); play(2'b01); play(2'b10); play(2'b00); play(2'b00);
        idle(10);

        drive(1'b0, 1'b1, 1'b0, 2'b00);
        play(2'b01); play(2'b01);
        drive(1'b0, 1'b1, 1'b1, 2'b01);
        play(2'b10);
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        idle(2);

        drive(1'b0, 1'b1, 1'b0, 2'b00);
        play(2'b10); play(2'b10); play(2'b10);
        idle(20);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            logic r, nm, rv;
            logic [1:0] rs;
            r  = ($urandom_range(0, 199) == 0);
            nm = ($urandom_range(0, 29) == 0);
            rv = ($urandom_range(0, 2) != 0);
            rs = 2'($urandom_range(0, 3));
            drive(r, nm, rv, rs);
        end
        idle(12);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
